// File: rtl/tri_mode_ethernet_mac_rx.sv
// tri_mode_ethernet_mac_rx
// Ethernet MAC receive path. Strips preamble/SFD from the RGMII byte-strobe
// stream, checks FCS, length and RX_ER, and forwards destination MAC through
// the last data byte (FCS withheld) with a good/bad verdict on the last beat.
//
// Handshake: neither side has tready. tvalid is a one-cycle strobe per byte;
// a byte is transferred on every cycle where tvalid=1, and tlast/tuser are
// only meaningful while tvalid=1. Output strobes follow the input cadence.
//
// Optional feature macro: RX_STATS_EN (adds rx_good_frames/rx_bad_frames).
//
// Ports:
//   rx_mac_aclk, rx_mac_reset        clock, synchronous active-high reset
//   rx_axis_rgmii_t{data,valid,last,user}  byte stream from RGMII (tuser=RX_ER)
//   rx_axis_mac_t{data,valid,last,user}    payload stream (tuser=bad frame)
//   rx_state                         debug view of the receive FSM
//   rx_good_frames, rx_bad_frames    frame statistics (RX_STATS_EN only)
module tri_mode_ethernet_mac_rx #(
  parameter int C_MIN_LEN = 64,
  parameter int C_MAX_LEN = 1518
) (
  input  logic        rx_mac_aclk,
  input  logic        rx_mac_reset,
  input  logic [7:0]  rx_axis_rgmii_tdata,
  input  logic        rx_axis_rgmii_tvalid,
  input  logic        rx_axis_rgmii_tlast,
  input  logic        rx_axis_rgmii_tuser,
  output logic [7:0]  rx_axis_mac_tdata,
  output logic        rx_axis_mac_tvalid,
  output logic        rx_axis_mac_tlast,
  output logic        rx_axis_mac_tuser,
  output logic [1:0]  rx_state
`ifdef RX_STATS_EN
  ,
  output logic [31:0] rx_good_frames,
  output logic [31:0] rx_bad_frames
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [11:0] MIN_LEN     = 12'(C_MIN_LEN);
  localparam logic [11:0] MAX_LEN     = 12'(C_MAX_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  state_t      state_q, state_d;
  logic [31:0] crc_q;
  logic [31:0] sr_q;      // byte [31:24] is the oldest withheld byte
  logic [2:0]  fill_q;    // number of valid bytes in sr_q (0..4)
  logic [11:0] len_q;
  logic        er_q;

  // Non-reflected CRC-32 register fed LSB-first, so a frame with a correct
  // FCS leaves the fixed residue 0xC704DD7B in the register.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  logic        strobe;
  logic        sfd_accept;
  logic        data_byte;
  logic [31:0] crc_next;
  logic [11:0] len_next;
  logic        er_next;
  logic        bad_frame;

  assign strobe     = rx_axis_rgmii_tvalid;
  assign sfd_accept = strobe && (state_q == S_PREAMBLE) &&
                      (rx_axis_rgmii_tdata == 8'hD5) && !rx_axis_rgmii_tlast;
  assign data_byte  = strobe && (state_q == S_DATA);
  assign crc_next   = crc_step(crc_q, rx_axis_rgmii_tdata);
  assign len_next   = (len_q == 12'hFFF) ? len_q : len_q + 12'd1;
  assign er_next    = er_q | rx_axis_rgmii_tuser;
  assign bad_frame  = (crc_next != CRC_RESIDUE) || (len_next < MIN_LEN) ||
                      (len_next > MAX_LEN) || er_next;
  assign rx_state   = state_q;

  always_comb begin
    state_d = state_q;
    if (strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_axis_rgmii_tlast)              state_d = S_IDLE;
          else if (rx_axis_rgmii_tdata == 8'h55) state_d = S_PREAMBLE;
          else                                   state_d = S_DROP;
        end
        S_PREAMBLE: begin
          if (rx_axis_rgmii_tlast)              state_d = S_IDLE;
          else if (rx_axis_rgmii_tdata == 8'h55) state_d = S_PREAMBLE;
          else if (rx_axis_rgmii_tdata == 8'hD5) state_d = S_DATA;
          else                                   state_d = S_DROP;
        end
        S_DATA: if (rx_axis_rgmii_tlast) state_d = S_IDLE;
        S_DROP: if (rx_axis_rgmii_tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      state_q            <= S_IDLE;
      crc_q              <= 32'hFFFFFFFF;
      sr_q               <= 32'd0;
      fill_q             <= 3'd0;
      len_q              <= 12'd0;
      er_q               <= 1'b0;
      rx_axis_mac_tdata  <= 8'd0;
      rx_axis_mac_tvalid <= 1'b0;
      rx_axis_mac_tlast  <= 1'b0;
      rx_axis_mac_tuser  <= 1'b0;
    end else begin
      state_q            <= state_d;
      rx_axis_mac_tvalid <= 1'b0;
      rx_axis_mac_tlast  <= 1'b0;
      rx_axis_mac_tuser  <= 1'b0;
      if (sfd_accept) begin
        // RX_ER on the SFD byte itself already counts against the frame.
        crc_q  <= 32'hFFFFFFFF;
        fill_q <= 3'd0;
        len_q  <= 12'd0;
        er_q   <= rx_axis_rgmii_tuser;
      end else if (data_byte) begin
        crc_q <= crc_next;
        sr_q  <= {sr_q[23:0], rx_axis_rgmii_tdata};
        len_q <= len_next;
        er_q  <= er_next;
        if (fill_q == 3'd4) begin
          rx_axis_mac_tvalid <= 1'b1;
          rx_axis_mac_tdata  <= sr_q[31:24];
          rx_axis_mac_tlast  <= rx_axis_rgmii_tlast;
          rx_axis_mac_tuser  <= rx_axis_rgmii_tlast & bad_frame;
        end else begin
          fill_q <= fill_q + 3'd1;
        end
        if (rx_axis_rgmii_tlast) fill_q <= 3'd0;
      end
    end
  end

`ifdef RX_STATS_EN
  // A 1-to-4 byte frame emits no beat; its bad count lands on the same
  // one-cycle-later schedule as a flagged tlast beat.
  logic short_bad_q;

  always_ff @(posedge rx_mac_aclk) begin
    if (rx_mac_reset) begin
      short_bad_q    <= 1'b0;
      rx_good_frames <= 32'd0;
      rx_bad_frames  <= 32'd0;
    end else begin
      short_bad_q <= data_byte && rx_axis_rgmii_tlast && (fill_q != 3'd4);
      if (rx_axis_mac_tvalid && rx_axis_mac_tlast && !rx_axis_mac_tuser)
        rx_good_frames <= rx_good_frames + 32'd1;
      if ((rx_axis_mac_tvalid && rx_axis_mac_tlast && rx_axis_mac_tuser) || short_bad_q)
        rx_bad_frames <= rx_bad_frames + 32'd1;
    end
  end
`endif

endmodule
